mem_access_unit: RTL and testbench

- CPU-side initiator for the 1024 x 32 data memory (async read, sync write on `we`).
- Accepts byte/halfword/word load and store requests on a valid/ready handshake with byte addressing.
- Drives the RAM word port. Sub-word stores use read-modify-write; sub-word loads are lane-extracted and sign/zero extended.
- Returns one response per request on a valid/ready handshake.

---
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for the 1024 x 32 data RAM: byte/half/word access, read-modify-write sub-word stores.
// Optional build macro MAU_ALIGN_CHECK_EN rejects misaligned half/word requests with rsp_err.
module mem_access_unit #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              uns_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              req_bad;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [DATA_W-1:0] load_value;
    logic [DATA_W-1:0] merged;

    always_comb begin
        req_bad = (size_q == SIZE_RSVD);
`ifdef MAU_ALIGN_CHECK_EN
        if (size_q == SIZE_HALF && addr_q[0])
            req_bad = 1'b1;
        if (size_q == SIZE_WORD && addr_q[1:0] != 2'b00)
            req_bad = 1'b1;
`endif
    end

    // Without the alignment check the unused low address bits simply fall out of the lane select.
    always_comb begin
        byte_lane  = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
        half_lane  = ram_rdata[{addr_q[1], 4'b0000} +: 16];
        load_value = ram_rdata;
        case (size_q)
            SIZE_BYTE: load_value = {{24{~uns_q & byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_value = {{16{~uns_q & half_lane[15]}}, half_lane};
            default:   load_value = ram_rdata;
        endcase
    end

    always_comb begin
        merged = old_q;
        if (size_q == SIZE_BYTE)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // Write strobe depends only on the state register so a reset cycle never starts a new write.
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        case (state)
            IDLE: begin
                if (req_valid)
                    state_next = ACCESS;
            end
            ACCESS: begin
                if (req_bad || !we_q || size_q == SIZE_WORD)
                    state_next = RESP;
                else
                    state_next = MERGE;
                if (!req_bad && we_q && size_q == SIZE_WORD) begin
                    ram_we    = 1'b1;
                    ram_wdata = wdata_q;
                end
            end
            MERGE: begin
                ram_we     = 1'b1;
                ram_wdata  = merged;
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            size_q  <= SIZE_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        we_q    <= req_we;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ACCESS: begin
                    err_q <= req_bad;
                    if (!req_bad && !we_q)
                        rdata_q <= load_value;
                    if (!req_bad && we_q)
                        old_q <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ram_addr  = addr_q[ADDR_W-1:2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random loads/stores against an array model.
// Build with or without MAU_ALIGN_CHECK_EN; the model follows the same macro.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [31:0] mem    [0:1023];
    logic [31:0] refMem [0:1023];
    logic        fillEn = 1'b0;
    logic [9:0]  fillIdx = '0;
    logic [31:0] fillData = '0;

    int assertCount = 0;
    int failCount   = 0;

    mem_access_unit #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_we       (ram_we),
        .ram_rdata    (ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM with async read and sync write; the fill port is a bench-only backdoor.
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (fillEn)
            mem[fillIdx] <= fillData;
        else if (ram_we)
            mem[ram_addr] <= ram_wdata;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pokeWord(input int idx, input logic [31:0] data);
        fillEn   = 1'b1;
        fillIdx  = idx[9:0];
        fillData = data;
        refMem[idx] = data;
        @(negedge clk);
        fillEn = 1'b0;
    endtask

    function automatic logic [31:0] extend(input logic [31:0] val, input int bits, input logic uns);
        logic [31:0] signBit;
        signBit = 32'd1 << (bits - 1);
        if (uns || val < signBit)
            return val;
        return val - (signBit * 2);
    endfunction

    // Reference behaviour: one request against the model array, producing the expected response.
    task automatic modelApply(input logic we, input logic [1:0] size, input logic uns,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              output logic [31:0] expRdata, output logic expErr,
                              output int expLat, output int expWe);
        int idx;
        int off;
        int sh;
        logic [31:0] word;
        logic misaligned;
        idx = int'(addr) / 4;
        off = int'(addr) % 4;
        word = refMem[idx];
        misaligned = 1'b0;
`ifdef MAU_ALIGN_CHECK_EN
        misaligned = (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
`endif
        expRdata = '0;
        expErr   = 1'b0;
        expLat   = 2;
        expWe    = 0;
        if (size == 2'd3 || misaligned) begin
            expErr = 1'b1;
        end else if (!we) begin
            if (size == 2'd0)
                expRdata = extend((word >> (8 * off)) & 32'hFF, 8, uns);
            else if (size == 2'd1)
                expRdata = extend((word >> (16 * (off / 2))) & 32'hFFFF, 16, uns);
            else
                expRdata = word;
        end else begin
            expWe = 1;
            if (size == 2'd2) begin
                refMem[idx] = wdata;
            end else if (size == 2'd0) begin
                expLat = 3;
                sh = 8 * off;
                refMem[idx] = (word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
            end else begin
                expLat = 3;
                sh = 16 * (off / 2);
                refMem[idx] = (word & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            end
        end
    endtask

    // Drives one request from IDLE, observes write strobes and latency, holds the response for stall cycles.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [11:0] addr, input logic [31:0] wdata, input int stall,
                                 output logic [31:0] gotRdata, output logic gotErr, output int gotLat,
                                 output int weCnt, output int weCyc, output logic [31:0] weData);
        logic [31:0] r;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        r = $urandom;
        req_valid    = 1'b0;
        req_we       = r[0];
        req_size     = r[2:1];
        req_unsigned = r[3];
        req_addr     = r[15:4];
        req_wdata    = $urandom;
        gotLat = -1;
        weCnt  = 0;
        weCyc  = -1;
        weData = '0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 1)
                checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
            if (ram_we) begin
                weCnt++;
                if (weCyc < 0) begin
                    weCyc  = cyc;
                    weData = ram_wdata;
                end
            end
            if (rsp_valid) begin
                gotLat = cyc;
                break;
            end
            @(negedge clk);
        end
        gotRdata = rsp_rdata;
        gotErr   = rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_rdata", rsp_rdata, gotRdata);
            checkOutput("stall_err", 32'(rsp_err), 32'(gotErr));
            checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
            checkOutput("stall_ram_we", 32'(ram_we), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic runCheck(input string tag, input logic we, input logic [1:0] size, input logic uns,
                            input logic [11:0] addr, input logic [31:0] wdata, input int stall,
                            output logic [31:0] gotRdata, output logic gotErr, output int gotLat,
                            output int weCyc, output logic [31:0] weData);
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expWe;
        int          weCnt;
        int          idx;
        idx = int'(addr) / 4;
        modelApply(we, size, uns, addr, wdata, expRdata, expErr, expLat, expWe);
        applyStimulus(we, size, uns, addr, wdata, stall, gotRdata, gotErr, gotLat, weCnt, weCyc, weData);
        checkOutput({tag, "_rdata"}, gotRdata, expRdata);
        checkOutput({tag, "_err"}, 32'(gotErr), 32'(expErr));
        checkOutput({tag, "_latency"}, 32'(gotLat), 32'(expLat));
        checkOutput({tag, "_we_count"}, 32'(weCnt), 32'(expWe));
        checkOutput({tag, "_we_cycle"}, 32'(weCyc), (expWe != 0) ? 32'(expLat - 1) : 32'hFFFF_FFFF);
        checkOutput({tag, "_ram_word"}, mem[idx], refMem[idx]);
    endtask

    logic [31:0] gotRdata;
    logic        gotErr;
    int          gotLat;
    int          weCyc;
    logic [31:0] weData;
    logic [31:0] expWord4;

    initial begin
        $display("[TB] start");
        for (int i = 0; i < 1024; i++) begin
            fillEn   = 1'b1;
            fillIdx  = i[9:0];
            fillData = $urandom;
            refMem[i] = fillData;
            @(negedge clk);
        end
        fillEn = 1'b0;
        rst    = 1'b0;

        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset_ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset_ram_wdata", ram_wdata, 32'd0);

        runCheck("wstore", 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 0, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("wstore_ram4", mem[4], 32'hDEADBEEF);
        checkOutput("wstore_wdata", weData, 32'hDEADBEEF);
        runCheck("wload", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 0, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("wload_const", gotRdata, 32'hDEADBEEF);

        pokeWord(1, 32'h11223344);
        runCheck("bstore", 1'b1, 2'd0, 1'b0, 12'h006, 32'h000000AA, 0, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("bstore_merge_cycle", 32'(weCyc), 32'd2);
        checkOutput("bstore_merge_data", weData, 32'h11AA3344);
        checkOutput("bstore_latency", 32'(gotLat), 32'd3);

        pokeWord(2, 32'h80FF7F01);
        runCheck("lb_signed", 1'b0, 2'd0, 1'b0, 12'h00A, 32'h0, 0, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("lb_signed_const", gotRdata, 32'hFFFFFFFF);
        runCheck("lh_unsigned", 1'b0, 2'd1, 1'b1, 12'h00A, 32'h0, 0, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("lh_unsigned_const", gotRdata, 32'h000080FF);
        runCheck("lh_signed", 1'b0, 2'd1, 1'b0, 12'h00A, 32'h0, 0, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("lh_signed_const", gotRdata, 32'hFFFF80FF);

        runCheck("backpressure", 1'b0, 2'd2, 1'b0, 12'h008, 32'h0, 5, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("backpressure_const", gotRdata, 32'h80FF7F01);

        pokeWord(5, 32'h12345678);
        runCheck("reserved", 1'b1, 2'd3, 1'b0, 12'h014, 32'hFFFFFFFF, 0, gotRdata, gotErr, gotLat, weCyc, weData);
        checkOutput("reserved_err", 32'(gotErr), 32'd1);
        checkOutput("reserved_ram5", mem[5], 32'h12345678);

        runCheck("misalign", 1'b1, 2'd2, 1'b0, 12'h013, 32'hCAFEF00D, 0, gotRdata, gotErr, gotLat, weCyc, weData);
`ifdef MAU_ALIGN_CHECK_EN
        expWord4 = 32'hDEADBEEF;
`else
        expWord4 = 32'hCAFEF00D;
`endif
        checkOutput("misalign_ram4", mem[4], expWord4);

        // Reset while the merge is still pending: nothing may be written.
        pokeWord(6, 32'hA5A5A5A5);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr  = 12'h019; req_wdata = 32'h00000055;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_access_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_access_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_access_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        checkOutput("rst_access_ram6", mem[6], 32'hA5A5A5A5);

        // Reset during the merge cycle: that write still lands, then the unit is idle.
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_merge_we", 32'(ram_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        refMem[6] = 32'hA5A555A5;
        checkOutput("rst_merge_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_merge_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_merge_ram6", mem[6], 32'hA5A555A5);

        for (int n = 0; n < 80; n++) begin
            logic [31:0] r;
            logic [11:0] a;
            r = $urandom;
            a = (r[4]) ? {6'd0, r[25:20]} : r[31:20];
            runCheck("random", r[0], r[2:1], r[3], a, $urandom, $urandom_range(2, 0),
                     gotRdata, gotErr, gotLat, weCyc, weData);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
